imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Byte-stream program loader feeding the instruction memory of the Olivia core.
//  Accepts a length-prefixed byte stream over a valid/ready handshake and writes it
//  MSB-first into byte-addressed IM (big-endian: word i occupies bytes 4i..4i+3).
//  Holds the core in reset while loading and releases it when the program is complete.
// PARAMETERS
//  IMEM_BYTES  64  instruction memory size in bytes (multiple of 4)
//  ADDR_W      6   IM byte-address width, log2(IMEM_BYTES)
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         reset: synchronous, active-high
//  in_valid     in   1         stream byte valid
//  in_data      in   8         stream byte
//  in_ready     out  1         loader can accept byte this cycle
//  im_we        out  1         IM byte write enable (one-cycle pulse per byte)
//  im_addr      out  ADDR_W    IM byte address
//  im_wdata     out  8         IM write byte
//  core_rst     out  1         reset to Olivia core (drives its rst)
//  load_done    out  1         program loaded, core running
//  load_err     out  1         malformed stream, core held in reset
//  word_cnt     out  ADDR_W-1  32-bit words fully written so far
// BEHAVIOUR
//  - Handshake: byte accepted on rising clk when in_valid && in_ready; in_ready is
//    combinational from state only (never depends on in_valid).
//  - States: HDR -> DATA -> [CHK] -> DONE; any state -> ERR on fault. DONE/ERR are
//    terminal until rst.
//  - Reset (cycle rst high): state=HDR, in_ready=1 after release, im_we=0, im_addr=0,
//    im_wdata=0, core_rst=1, load_done=0, load_err=0, word_cnt=0, byte counter=0.
//  - HDR: in_ready=1. First accepted byte = word count N. N==0 or N>IMEM_BYTES/4 -> ERR;
//    else latch N, go DATA.
//  - DATA: in_ready=1. Each accepted byte registered: next cycle im_we=1,
//    im_addr=byte index (0,1,2,...), im_wdata=byte. Latency 1 cycle; im_we low in
//    cycles with no accept. word_cnt increments on the cycle the 4th byte of a word
//    is written. After byte 4N-1 accepted -> CHK (macro on) or DONE (macro off).
//  - im_addr holds its last value when im_we=0; address never exceeds 4N-1 (N bound
//    guarantees no wrap).
//  - DONE: in_ready=0, load_done=1, core_rst=0 from the cycle after the final write
//    (final IM write completes before the core leaves reset).
//  - ERR: in_ready=0, load_err=1, core_rst=1. Already-written bytes are not cleared.
//  - IM bytes beyond 4N-1 are untouched (zero-initialised IM executes as NOP).
//  - rst mid-load: immediate return to HDR, counters cleared, core_rst=1; partially
//    written IM contents remain and are overwritten by the next load.
//  - in_valid while in_ready=0 is ignored (byte not consumed, no error).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the 4N data bytes, state CHK (in_ready=1)
//    accepts one byte; equal to XOR of all 4N data bytes -> DONE, else -> ERR.
//    Running XOR register cleared on rst.
//  Undefined: no CHK state, no XOR register; DONE directly after last data byte.
// TESTING
//  1 rst 2 cycles -> all outputs at reset values, core_rst=1, in_ready=1.
//  2 stream 01,8B,02,00,20 (ADD X0,X1,X2), in_valid held high -> IM[0..3]=8B,02,00,20,
//    im_we 4 consecutive cycles, word_cnt=1, load_done=1, core_rst=0 next cycle.
//  3 header 00, and header 11 (17 > 16) -> load_err=1, no im_we pulse, core_rst=1.
//  4 N=2 stream with in_valid gapped every other cycle -> addresses 0..7 in order, no
//    duplicates; bytes offered after DONE ignored (in_ready=0).
//  5 rst asserted after 3 data bytes, then full N=1 load of F8400020 -> IM[0..3]
//    = F8,40,00,20, load_done=1.
//  6 (CHECKSUM_EN) 01,8B,02,00,20,A9 -> DONE; same with trailer 00 -> ERR.

Source files
------------

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the Olivia instruction memory; holds the core in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_BYTES = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-2:0] word_cnt
);

    // state   | meaning
    // ST_HDR  | waiting for word-count header byte
    // ST_DATA | receiving 4N program bytes
    // ST_CHK  | waiting for XOR checksum byte (checksum build only)
    // ST_DONE | program loaded, core released
    // ST_ERR  | malformed stream, core held in reset
    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] LP_MAX_WORDS = 8'(IMEM_BYTES / 4);

    state_t            r_state;
    logic [ADDR_W-2:0] r_n;
    logic [ADDR_W-1:0] r_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    logic              w_accept;
    logic [ADDR_W:0]   w_last_idx;
    logic              w_is_last;

    always_comb begin
        in_ready = (r_state == ST_HDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    end

    assign w_accept   = in_valid && in_ready;
    // One bit wider than the address so N == IMEM_BYTES/4 gives 4N-1 without wrap.
    assign w_last_idx = {r_n, 2'b00} - (ADDR_W + 1)'(1);
    assign w_is_last  = ({1'b0, r_idx} == w_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HDR;
            r_n       <= '0;
            r_idx     <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_accept) begin
                        if ((in_data == 8'd0) || (in_data > LP_MAX_WORDS)) begin
                            r_state  <= ST_ERR;
                            load_err <= 1'b1;
                        end else begin
                            r_n     <= in_data[ADDR_W-2:0];
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        im_we    <= 1'b1;
                        im_addr  <= r_idx;
                        im_wdata <= in_data;
                        r_idx    <= r_idx + 1'b1;
                        if (r_idx[1:0] == 2'b11) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data;
                        if (w_is_last) begin
                            r_state <= ST_CHK;
                        end
`else
                        if (w_is_last) begin
                            r_state <= ST_DONE;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_accept) begin
                        if (in_data == r_xor) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state  <= ST_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    // Entered on the final write edge, so release lands one cycle after it.
                    load_done <= 1'b1;
                    core_rst  <= 1'b0;
                end
                ST_ERR: begin
                    load_err <= 1'b1;
                    core_rst <= 1'b1;
                end
                default: begin
                    r_state  <= ST_ERR;
                    load_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: cycle table for a one-word load plus hand sequences for error, gap and reset cases.
module tb_imem_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       im_we;
    logic [5:0] im_addr;
    logic [7:0] im_wdata;
    logic       core_rst;
    logic       load_done;
    logic       load_err;
    logic [4:0] word_cnt;

    imem_loader #(.IMEM_BYTES(64), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .core_rst  (core_rst),
        .load_done (load_done),
        .load_err  (load_err),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wd;
        logic [4:0] wc;
        logic       done;
        logic       crst;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] mem[64];
    int         wr_q[$];
    int         n_chk;
    int         n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock and log any IM write presented after that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (im_we === 1'b1) begin
            wr_q.push_back(int'(im_addr));
            mem[im_addr] = im_wdata;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    endtask

    task automatic push(input logic [7:0] b, input bit gap);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (gap) tick();
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values
        do_reset();
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_im_we",     im_we,     0);
        chk("rst_im_addr",   im_addr,   0);
        chk("rst_im_wdata",  im_wdata,  0);
        chk("rst_core_rst",  core_rst,  1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_err",  load_err,  0);
        chk("rst_word_cnt",  word_cnt,  0);

        // One-word load, in_valid held high; row = inputs this cycle, outputs after the edge
        tbl.push_back(vec_t'{1'b1, 8'h01, 1'b1, 1'b0, 6'd0, 8'h00, 5'd0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 8'h8B, 1'b1, 1'b1, 6'd0, 8'h8B, 5'd0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 8'h02, 1'b1, 1'b1, 6'd1, 8'h02, 5'd0, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 8'h00, 1'b1, 1'b1, 6'd2, 8'h00, 5'd0, 1'b0, 1'b1});
`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back(vec_t'{1'b1, 8'h20, 1'b1, 1'b1, 6'd3, 8'h20, 5'd1, 1'b0, 1'b1});
        tbl.push_back(vec_t'{1'b1, 8'hA9, 1'b1, 1'b0, 6'd3, 8'h20, 5'd1, 1'b0, 1'b1});
`else
        tbl.push_back(vec_t'{1'b1, 8'h20, 1'b1, 1'b1, 6'd3, 8'h20, 5'd1, 1'b0, 1'b1});
`endif
        tbl.push_back(vec_t'{1'b1, 8'hFF, 1'b0, 1'b0, 6'd3, 8'h20, 5'd1, 1'b1, 1'b0});
        tbl.push_back(vec_t'{1'b1, 8'h55, 1'b0, 1'b0, 6'd3, 8'h20, 5'd1, 1'b1, 1'b0});

        do_reset();
        foreach (tbl[k]) begin
            in_valid = tbl[k].v;
            in_data  = tbl[k].d;
            #1;
            chk($sformatf("t2_ready_%0d", k), in_ready, tbl[k].rdy);
            tick();
            chk($sformatf("t2_we_%0d", k),    im_we,     tbl[k].we);
            chk($sformatf("t2_addr_%0d", k),  im_addr,   tbl[k].addr);
            chk($sformatf("t2_wdata_%0d", k), im_wdata,  tbl[k].wd);
            chk($sformatf("t2_wcnt_%0d", k),  word_cnt,  tbl[k].wc);
            chk($sformatf("t2_done_%0d", k),  load_done, tbl[k].done);
            chk($sformatf("t2_crst_%0d", k),  core_rst,  tbl[k].crst);
            chk($sformatf("t2_err_%0d", k),   load_err,  0);
        end
        in_valid = 1'b0;
        chk("t2_mem0", mem[0], 8'h8B);
        chk("t2_mem1", mem[1], 8'h02);
        chk("t2_mem2", mem[2], 8'h00);
        chk("t2_mem3", mem[3], 8'h20);
        chk("t2_nwr",  wr_q.size(), 4);

        // Bad headers: zero and one word past capacity
        do_reset();
        push(8'h00, 1'b0);
        chk("t3a_err",   load_err, 1);
        chk("t3a_crst",  core_rst, 1);
        chk("t3a_ready", in_ready, 0);
        push(8'h01, 1'b0);
        push(8'h55, 1'b0);
        tick();
        chk("t3a_nwr",   wr_q.size(), 0);
        chk("t3a_done",  load_done, 0);
        chk("t3a_err2",  load_err, 1);

        do_reset();
        push(8'h11, 1'b0);
        tick();
        chk("t3b_err",   load_err, 1);
        chk("t3b_crst",  core_rst, 1);
        chk("t3b_ready", in_ready, 0);
        chk("t3b_nwr",   wr_q.size(), 0);

        // Header at exact capacity is legal
        do_reset();
        push(8'h10, 1'b0);
        chk("t3c_err",   load_err, 0);
        chk("t3c_ready", in_ready, 1);

        // Two words with gapped in_valid
        do_reset();
        push(8'h02, 1'b1);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(8'h00, 1'b1);
`endif
        tick();
        chk("t4_nwr",  wr_q.size(), 8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            chk($sformatf("t4_addr_%0d", i), wr_q[i], i);
            chk($sformatf("t4_mem_%0d", i), mem[i], 8'(8'h10 + i));
        end
        chk("t4_mem8",  mem[8], 8'h00);
        chk("t4_wcnt",  word_cnt, 2);
        chk("t4_done",  load_done, 1);
        chk("t4_crst",  core_rst, 0);
        chk("t4_ready", in_ready, 0);
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        chk("t4_nwr_after",  wr_q.size(), 8);
        chk("t4_done_after", load_done, 1);

        // Reset mid-load then a full reload
        do_reset();
        push(8'h01, 1'b0);
        push(8'h8B, 1'b0);
        push(8'h02, 1'b0);
        push(8'h00, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_crst",  core_rst, 1);
        chk("t5_rst_wcnt",  word_cnt, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_we",    im_we, 0);
        chk("t5_rst_addr",  im_addr, 0);
        wr_q.delete();
        push(8'h01, 1'b0);
        push(8'hF8, 1'b0);
        push(8'h40, 1'b0);
        push(8'h00, 1'b0);
        push(8'h20, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push(8'h98, 1'b0);
`endif
        tick();
        chk("t5_mem0", mem[0], 8'hF8);
        chk("t5_mem1", mem[1], 8'h40);
        chk("t5_mem2", mem[2], 8'h00);
        chk("t5_mem3", mem[3], 8'h20);
        chk("t5_nwr",  wr_q.size(), 4);
        chk("t5_done", load_done, 1);
        chk("t5_crst", core_rst, 0);
        chk("t5_wcnt", word_cnt, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum trailer: correct then corrupted
        do_reset();
        push(8'h01, 1'b0);
        push(8'h8B, 1'b0);
        push(8'h02, 1'b0);
        push(8'h00, 1'b0);
        push(8'h20, 1'b0);
        chk("t6a_ready", in_ready, 1);
        chk("t6a_done0", load_done, 0);
        push(8'hA9, 1'b0);
        tick();
        chk("t6a_done", load_done, 1);
        chk("t6a_err",  load_err, 0);
        chk("t6a_crst", core_rst, 0);

        do_reset();
        push(8'h01, 1'b0);
        push(8'h8B, 1'b0);
        push(8'h02, 1'b0);
        push(8'h00, 1'b0);
        push(8'h20, 1'b0);
        push(8'h00, 1'b0);
        tick();
        chk("t6b_err",  load_err, 1);
        chk("t6b_done", load_done, 0);
        chk("t6b_crst", core_rst, 1);
        chk("t6b_mem3", mem[3], 8'h20);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
